layer_sequencer: RTL and testbench

Descriptor-driven, parametrised top-level sequencer for the CNN inference core. It replaces hard-wired per-layer control with a programmable layer table of up to NUM_LAYERS entries. For each layer it launches the conv, maxp, dense or result engine through an enable/STOP handshake, and ping-pongs the two pixel-RAM banks between layers. It also accumulates the weight-RAM base address and presents the final 4-bit class on RESULT.

---
 rtl/layer_sequencer_if.sv | 27 ++
 rtl/layer_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// Engine-side handshake bundle of the layer sequencer: one enable/STOP pair per
// engine plus the class index returned by the result engine.
`default_nettype none

interface layer_sequencer_if;
  logic       conv_en;
  logic       maxp_en;
  logic       dense_en;
  logic       result_en;
  logic       STOP_conv;
  logic       STOP_maxp;
  logic       STOP_dense;
  logic       STOP_res;
  logic [3:0] res_out;

  modport master (
    output conv_en, maxp_en, dense_en, result_en,
    input  STOP_conv, STOP_maxp, STOP_dense, STOP_res, res_out
  );

  modport slave (
    input  conv_en, maxp_en, dense_en, result_en,
    output STOP_conv, STOP_maxp, STOP_dense, STOP_res, res_out
  );
endinterface

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ============================================================================
// layer_sequencer
//   Descriptor-table driven CNN layer sequencer: launches conv/maxp/dense/
//   result engines, ping-pongs the pixel banks and accumulates the weight base.
//   Optional watchdog: define LAYER_SEQ_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_sequencer #(
  parameter int NUM_LAYERS       = 16,
  parameter int SIZE_address_pix = 13,
  parameter int SIZE_address_wei = 9,
  parameter int BANK_A_BASE      = 0,
  parameter int BANK_B_BASE      = 3136,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          GO,
  input  logic                          desc_we,
  input  logic [$clog2(NUM_LAYERS)-1:0] desc_addr,
  input  logic [17:0]                   desc_data,
  layer_sequencer_if.master             eng,
  output logic [SIZE_address_pix-1:0]   memstartp,
  output logic [SIZE_address_pix-1:0]   memstartzap,
  output logic [SIZE_address_wei-1:0]   memstartw,
  output logic [4:0]                    matrix,
  output logic [4:0]                    mem,
  output logic [4:0]                    filt,
  output logic                          globmaxp_en,
  output logic [$clog2(NUM_LAYERS)-1:0] layer_idx,
  output logic                          STOP,
  output logic [3:0]                    RESULT,
  output logic                          err
);

  localparam int LW = $clog2(NUM_LAYERS);
  localparam logic [1:0] c_OP_CONV   = 2'd0;
  localparam logic [1:0] c_OP_MAXP   = 2'd1;
  localparam logic [1:0] c_OP_DENSE  = 2'd2;
  localparam logic [1:0] c_OP_RESULT = 2'd3;
  localparam logic [SIZE_address_pix-1:0] c_BANK_A = SIZE_address_pix'(BANK_A_BASE);
  localparam logic [SIZE_address_pix-1:0] c_BANK_B = SIZE_address_pix'(BANK_B_BASE);
  localparam logic [LW-1:0] c_LAST = LW'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ARM, S_RUN, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t                      state_q;
  logic [17:0]                 desc_tbl_q [NUM_LAYERS];
  logic [1:0]                  op_q;
  logic [4:0]                  matrix_q, mem_q, filt_q;
  logic                        gmp_q;
  logic [LW-1:0]               layer_q;
  logic [SIZE_address_pix-1:0] memstartp_q, memstartzap_q;
  logic [SIZE_address_wei-1:0] memstartw_q;
  logic                        conv_en_q, maxp_en_q, dense_en_q, result_en_q;
  logic                        stop_q;
  logic [3:0]                  result_q;

  logic        cfg_ok;
  logic        start;
  logic        sel_stop;
  logic        tmo_fire;
  logic [17:0] cur_desc;
  logic [5:0]  in_ch, out_ch;
  logic [11:0] w_prod;

  assign cfg_ok   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign start    = GO && cfg_ok;
  assign cur_desc = desc_tbl_q[layer_q];
  assign in_ch    = {1'b0, mem_q} + 6'd1;
  assign out_ch   = {1'b0, filt_q} + 6'd1;
  assign w_prod   = {6'd0, in_ch} * {6'd0, out_ch};

  always_comb begin
    sel_stop = 1'b0;
    case (op_q)
      c_OP_CONV:  sel_stop = eng.STOP_conv;
      c_OP_MAXP:  sel_stop = eng.STOP_maxp;
      c_OP_DENSE: sel_stop = eng.STOP_dense;
      default:    sel_stop = eng.STOP_res;
    endcase
  end

  // Table has no reset: contents survive rst so a program can be re-run.
  always_ff @(posedge clk) begin
    if (desc_we && cfg_ok) begin
      desc_tbl_q[desc_addr] <= desc_data;
    end
  end

`ifdef LAYER_SEQ_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        err_q;

  assign tmo_fire = (state_q == S_RUN) && !sel_stop && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_ARM) begin
        tmo_q <= 16'd0;
      end else if (state_q == S_RUN) begin
        tmo_q <= tmo_q + 16'd1;
      end
      if (start) begin
        err_q <= 1'b0;
      end else if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= c_OP_CONV;
      matrix_q      <= 5'd0;
      mem_q         <= 5'd0;
      filt_q        <= 5'd0;
      gmp_q         <= 1'b0;
      layer_q       <= '0;
      memstartp_q   <= c_BANK_A;
      memstartzap_q <= c_BANK_B;
      memstartw_q   <= '0;
      conv_en_q     <= 1'b0;
      maxp_en_q     <= 1'b0;
      dense_en_q    <= 1'b0;
      result_en_q   <= 1'b0;
      stop_q        <= 1'b0;
      result_q      <= 4'hF;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            layer_q       <= '0;
            memstartp_q   <= c_BANK_A;
            memstartzap_q <= c_BANK_B;
            memstartw_q   <= '0;
            stop_q        <= 1'b0;
            result_q      <= 4'hF;
            state_q       <= S_FETCH;
          end
        end
        S_FETCH: begin
          op_q     <= cur_desc[17:16];
          matrix_q <= cur_desc[15:11];
          mem_q    <= cur_desc[10:6];
          filt_q   <= cur_desc[5:1];
          gmp_q    <= cur_desc[0];
          state_q  <= S_ARM;
        end
        S_ARM: begin
          // Engines idle with STOP high; launch only once the previous run's STOP cleared.
          if (!sel_stop) begin
            conv_en_q   <= (op_q == c_OP_CONV);
            maxp_en_q   <= (op_q == c_OP_MAXP);
            dense_en_q  <= (op_q == c_OP_DENSE);
            result_en_q <= (op_q == c_OP_RESULT);
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          if (sel_stop || tmo_fire) begin
            conv_en_q   <= 1'b0;
            maxp_en_q   <= 1'b0;
            dense_en_q  <= 1'b0;
            result_en_q <= 1'b0;
            if (sel_stop) begin
              state_q <= S_NEXT;
            end else begin
              stop_q  <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        S_NEXT: begin
          if (op_q == c_OP_RESULT) begin
            result_q <= eng.res_out;
            stop_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            if (op_q != c_OP_MAXP) begin
              memstartw_q <= memstartw_q + SIZE_address_wei'(w_prod);
            end
            memstartp_q   <= memstartzap_q;
            memstartzap_q <= memstartp_q;
            if (layer_q == c_LAST) begin
              stop_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              layer_q <= layer_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng.conv_en   = conv_en_q;
  assign eng.maxp_en   = maxp_en_q;
  assign eng.dense_en  = dense_en_q;
  assign eng.result_en = result_en_q;
  assign memstartp     = memstartp_q;
  assign memstartzap   = memstartzap_q;
  assign memstartw     = memstartw_q;
  assign matrix        = matrix_q;
  assign mem           = mem_q;
  assign filt          = filt_q;
  assign globmaxp_en   = gmp_q;
  assign layer_idx     = layer_q;
  assign STOP          = stop_q;
  assign RESULT        = result_q;

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a 16-entry instance with a latency-programmable
// engine responder, plus a 4-entry instance for table exhaustion.
`default_nettype none

module tb_layer_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        GO, desc_we;
  logic [3:0]  desc_addr;
  logic [17:0] desc_data;
  logic [12:0] memstartp, memstartzap;
  logic [8:0]  memstartw;
  logic [4:0]  matrix, mem, filt;
  logic        globmaxp_en, STOP, err;
  logic [3:0]  layer_idx, RESULT;

  logic        GO4, desc_we4;
  logic [1:0]  desc_addr4;
  logic [17:0] desc_data4;
  logic [12:0] memstartp4, memstartzap4;
  logic [8:0]  memstartw4;
  logic [4:0]  matrix4, mem4, filt4;
  logic        globmaxp_en4, STOP4, err4;
  logic [1:0]  layer_idx4;
  logic [3:0]  RESULT4;

  layer_sequencer_if bus ();
  layer_sequencer_if bus4 ();

  layer_sequencer #(.NUM_LAYERS(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .GO(GO), .desc_we(desc_we), .desc_addr(desc_addr),
    .desc_data(desc_data), .eng(bus), .memstartp(memstartp), .memstartzap(memstartzap),
    .memstartw(memstartw), .matrix(matrix), .mem(mem), .filt(filt),
    .globmaxp_en(globmaxp_en), .layer_idx(layer_idx), .STOP(STOP), .RESULT(RESULT), .err(err)
  );

  layer_sequencer #(.NUM_LAYERS(4), .TIMEOUT_CYCLES(100)) dut4 (
    .clk(clk), .rst(rst), .GO(GO4), .desc_we(desc_we4), .desc_addr(desc_addr4),
    .desc_data(desc_data4), .eng(bus4), .memstartp(memstartp4), .memstartzap(memstartzap4),
    .memstartw(memstartw4), .matrix(matrix4), .mem(mem4), .filt(filt4),
    .globmaxp_en(globmaxp_en4), .layer_idx(layer_idx4), .STOP(STOP4), .RESULT(RESULT4), .err(err4)
  );

  int errors = 0;
  int checks = 0;

  // Engine responder: STOP rises lat[e] cycles into a run, drops once enable falls.
  int       lat [4];
  int       cnt [4];
  bit       force_hi [4];
  logic [3:0] st, en_v;
  initial begin
    st = 4'b0;
    for (int e = 0; e < 4; e++) begin lat[e] = 2; cnt[e] = 0; force_hi[e] = 1'b0; end
    bus.STOP_conv = 1'b0; bus.STOP_maxp = 1'b0; bus.STOP_dense = 1'b0; bus.STOP_res = 1'b0;
    forever begin
      @(negedge clk);
      en_v = {bus.result_en, bus.dense_en, bus.maxp_en, bus.conv_en};
      for (int e = 0; e < 4; e++) begin
        if (en_v[e]) begin
          cnt[e]++;
          if (cnt[e] >= lat[e]) st[e] = 1'b1;
        end else begin
          cnt[e] = 0;
          st[e]  = force_hi[e];
        end
      end
      bus.STOP_conv = st[0]; bus.STOP_maxp = st[1]; bus.STOP_dense = st[2]; bus.STOP_res = st[3];
    end
  end

  // Records the weight/bank pointers seen at the start of every launch.
  int q_w[$], q_p[$], q_l[$];
  int res_hi = 0;
  bit prev_any = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if ((bus.conv_en | bus.maxp_en | bus.dense_en | bus.result_en) && !prev_any) begin
        q_w.push_back(int'(memstartw));
        q_p.push_back(int'(memstartp));
        q_l.push_back(int'(layer_idx));
      end
      prev_any = bus.conv_en | bus.maxp_en | bus.dense_en | bus.result_en;
      if (bus.result_en) res_hi++;
    end
  end

  // Responder for the 4-entry instance (maxp only, 2-cycle latency).
  int cnt4 = 0;
  int starts4 = 0;
  bit prev4 = 1'b0;
  initial begin
    bus4.STOP_conv = 1'b0; bus4.STOP_maxp = 1'b0; bus4.STOP_dense = 1'b0; bus4.STOP_res = 1'b0;
    bus4.res_out = 4'd5;
    forever begin
      @(negedge clk);
      if (bus4.maxp_en) begin
        cnt4++;
        if (cnt4 >= 2) bus4.STOP_maxp = 1'b1;
      end else begin
        cnt4 = 0;
        bus4.STOP_maxp = 1'b0;
      end
      if (bus4.maxp_en && !prev4) starts4++;
      prev4 = bus4.maxp_en;
    end
  end

  function automatic logic [17:0] mk(input logic [1:0] op, input logic [4:0] mtx,
                                     input logic [4:0] in_m1, input logic [4:0] out_m1,
                                     input logic gmp);
    return {op, mtx, in_m1, out_m1, gmp};
  endfunction

  task automatic wr(input int a, input logic [17:0] d);
    @(negedge clk); desc_we = 1'b1; desc_addr = 4'(a); desc_data = d;
    @(negedge clk); desc_we = 1'b0;
  endtask

  task automatic go();
    @(negedge clk); GO = 1'b1;
    @(negedge clk); GO = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (STOP) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic clear_log();
    q_w.delete(); q_p.delete(); q_l.delete(); res_hi = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (STOP !== 1'b0) begin errors++; $display("FAIL reset_stop got=%0b exp=0", STOP); end
    checks++; if (RESULT !== 4'hF) begin errors++; $display("FAIL reset_result got=%0d exp=15", RESULT); end
    checks++; if (memstartp !== 13'd0) begin errors++; $display("FAIL reset_memstartp got=%0d exp=0", memstartp); end
    checks++; if (memstartzap !== 13'd3136) begin errors++; $display("FAIL reset_memstartzap got=%0d exp=3136", memstartzap); end
    checks++; if (memstartw !== 9'd0) begin errors++; $display("FAIL reset_memstartw got=%0d exp=0", memstartw); end
    checks++; if (layer_idx !== 4'd0) begin errors++; $display("FAIL reset_layer_idx got=%0d exp=0", layer_idx); end
    checks++;
    if ({bus.conv_en, bus.maxp_en, bus.dense_en, bus.result_en} !== 4'b0) begin
      errors++; $display("FAIL reset_enables got=%b exp=0000", {bus.conv_en, bus.maxp_en, bus.dense_en, bus.result_en});
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++;
    if ({matrix, mem, filt, globmaxp_en} !== 16'd0) begin
      errors++; $display("FAIL reset_fields got=%h exp=0", {matrix, mem, filt, globmaxp_en});
    end
    checks++; if (STOP4 !== 1'b0) begin errors++; $display("FAIL reset_stop4 got=%0b exp=0", STOP4); end
  endtask

  task automatic test_single_layer();
    bit ok, bad;
    int cyc;
    wr(0, mk(2'd3, 5'd9, 5'd2, 5'd1, 1'b1));
    lat[3] = 5; bus.res_out = 4'd7;
    clear_log();
    go();
    @(negedge clk);
    checks++; if (bus.result_en !== 1'b0) begin errors++; $display("FAIL single_en_early got=%0b exp=0", bus.result_en); end
    @(negedge clk);
    checks++; if (bus.result_en !== 1'b1) begin errors++; $display("FAIL single_en_launch got=%0b exp=1", bus.result_en); end
    checks++;
    if ({matrix, mem, filt, globmaxp_en} !== {5'd9, 5'd2, 5'd1, 1'b1}) begin
      errors++; $display("FAIL single_fields got=%h exp=%h", {matrix, mem, filt, globmaxp_en}, {5'd9, 5'd2, 5'd1, 1'b1});
    end
    ok = 1'b0; bad = 1'b0; cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (STOP) begin ok = 1'b1; cyc = i; break; end
      if (RESULT !== 4'hF) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=STOP0 exp=STOP1"); end
    checks++; if (bad) begin errors++; $display("FAIL single_result_before got=not15 exp=15"); end
    checks++; if (cyc != 6) begin errors++; $display("FAIL single_stop_latency got=%0d exp=6", cyc); end
    checks++; if (res_hi != 5) begin errors++; $display("FAIL single_en_cycles got=%0d exp=5", res_hi); end
    checks++; if (RESULT !== 4'd7) begin errors++; $display("FAIL single_result got=%0d exp=7", RESULT); end
  endtask

  task automatic test_arm_handshake();
    bit ok;
    wr(0, mk(2'd0, 5'd4, 5'd0, 5'd0, 1'b0));
    wr(1, mk(2'd3, 5'd1, 5'd0, 5'd0, 1'b0));
    lat[0] = 3; lat[3] = 2; bus.res_out = 4'd2;
    force_hi[0] = 1'b1;
    @(negedge clk);
    go();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus.conv_en !== 1'b0) begin errors++; $display("FAIL arm_hold%0d got=%0b exp=0", k, bus.conv_en); end
      @(negedge clk);
    end
    @(posedge clk); #1 force_hi[0] = 1'b0;
    @(negedge clk);
    checks++; if (bus.conv_en !== 1'b0) begin errors++; $display("FAIL arm_fall_cycle got=%0b exp=0", bus.conv_en); end
    @(negedge clk);
    checks++; if (bus.conv_en !== 1'b1) begin errors++; $display("FAIL arm_launch got=%0b exp=1", bus.conv_en); end
    wait_done(100, ok);
    checks++; if (!ok || RESULT !== 4'd2) begin errors++; $display("FAIL arm_complete got=%0d exp=2", RESULT); end
  endtask

  task automatic test_pingpong();
    bit ok;
    int exp_w [5] = '{0, 4, 20, 20, 196};
    int exp_p [5] = '{0, 3136, 0, 3136, 0};
    wr(0, mk(2'd0, 5'd28, 5'd0,  5'd3,  1'b0));
    wr(1, mk(2'd0, 5'd28, 5'd3,  5'd3,  1'b0));
    wr(2, mk(2'd1, 5'd14, 5'd3,  5'd3,  1'b0));
    wr(3, mk(2'd2, 5'd1,  5'd15, 5'd10, 1'b1));
    wr(4, mk(2'd3, 5'd1,  5'd0,  5'd0,  1'b0));
    lat[0] = 3; lat[1] = 2; lat[2] = 4; lat[3] = 2; bus.res_out = 4'd3;
    clear_log();
    go();
    wait_done(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pp_timeout got=STOP0 exp=STOP1"); end
    checks++; if (q_w.size() != 5) begin errors++; $display("FAIL pp_launches got=%0d exp=5", q_w.size()); end
    for (int i = 0; i < 5 && i < q_w.size(); i++) begin
      checks++;
      if (q_w[i] != exp_w[i]) begin errors++; $display("FAIL pp_memstartw%0d got=%0d exp=%0d", i, q_w[i], exp_w[i]); end
      checks++;
      if (q_p[i] != exp_p[i]) begin errors++; $display("FAIL pp_memstartp%0d got=%0d exp=%0d", i, q_p[i], exp_p[i]); end
      checks++;
      if (q_l[i] != i) begin errors++; $display("FAIL pp_layer%0d got=%0d exp=%0d", i, q_l[i], i); end
    end
    checks++; if (RESULT !== 4'd3) begin errors++; $display("FAIL pp_result got=%0d exp=3", RESULT); end
  endtask

  task automatic test_exhaustion();
    bit ok;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk); desc_we4 = 1'b1; desc_addr4 = 2'(a); desc_data4 = mk(2'd1, 5'd7, 5'd1, 5'd1, 1'b0);
    end
    @(negedge clk); desc_we4 = 1'b0;
    starts4 = 0;
    @(negedge clk); GO4 = 1'b1;
    @(negedge clk); GO4 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (STOP4) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL exh_timeout got=STOP0 exp=STOP1"); end
    checks++; if (RESULT4 !== 4'hF) begin errors++; $display("FAIL exh_result got=%0d exp=15", RESULT4); end
    checks++; if (layer_idx4 !== 2'd3) begin errors++; $display("FAIL exh_layer_idx got=%0d exp=3", layer_idx4); end
    checks++; if (starts4 != 4) begin errors++; $display("FAIL exh_launches got=%0d exp=4", starts4); end
    checks++; if (memstartw4 !== 9'd0) begin errors++; $display("FAIL exh_memstartw got=%0d exp=0", memstartw4); end
  endtask

  task automatic test_reset_mid_run();
    bit ok, seen;
    wr(0, mk(2'd0, 5'd6, 5'd0,  5'd3,  1'b0));
    wr(1, mk(2'd2, 5'd6, 5'd15, 5'd10, 1'b1));
    wr(2, mk(2'd3, 5'd1, 5'd0,  5'd0,  1'b0));
    lat[0] = 3; lat[2] = 60; lat[3] = 2; bus.res_out = 4'd9;
    go();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.dense_en) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmr_dense_launch got=0 exp=1"); end
    checks++;
    if (memstartw !== 9'd4 || layer_idx !== 4'd1) begin
      errors++; $display("FAIL rmr_pre_state got=w%0d/l%0d exp=w4/l1", memstartw, layer_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.dense_en !== 1'b0) begin errors++; $display("FAIL rmr_dense_en got=%0b exp=0", bus.dense_en); end
    checks++;
    if (memstartw !== 9'd0 || memstartp !== 13'd0 || memstartzap !== 13'd3136) begin
      errors++; $display("FAIL rmr_ptrs got=%0d/%0d/%0d exp=0/0/3136", memstartw, memstartp, memstartzap);
    end
    checks++;
    if (layer_idx !== 4'd0 || STOP !== 1'b0 || RESULT !== 4'hF) begin
      errors++; $display("FAIL rmr_ctrl got=l%0d/s%0b/r%0d exp=l0/s0/r15", layer_idx, STOP, RESULT);
    end
    checks++;
    if ({matrix, mem, filt, globmaxp_en} !== 16'd0) begin
      errors++; $display("FAIL rmr_fields got=%h exp=0", {matrix, mem, filt, globmaxp_en});
    end
    rst = 1'b0;
    lat[2] = 4;
    repeat (3) @(negedge clk);
    clear_log();
    go();
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmr_rerun_timeout got=STOP0 exp=STOP1"); end
    checks++;
    if (q_l.size() != 3 || q_l[0] != 0 || q_w[0] != 0) begin
      errors++; $display("FAIL rmr_restart got=n%0d exp=n3 from layer0", q_l.size());
    end
    checks++; if (RESULT !== 4'd9) begin errors++; $display("FAIL rmr_result got=%0d exp=9", RESULT); end
  endtask

`ifdef LAYER_SEQ_TIMEOUT_EN
  task automatic test_watchdog();
    bit ok, seen;
    int hi;
    wr(0, mk(2'd0, 5'd3, 5'd0, 5'd0, 1'b0));
    wr(1, mk(2'd3, 5'd1, 5'd0, 5'd0, 1'b0));
    lat[0] = 100000; lat[3] = 2; bus.res_out = 4'd4;
    go();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.conv_en) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.conv_en) break;
      hi++;
      @(negedge clk);
    end
    checks++; if (!seen || hi != 100) begin errors++; $display("FAIL wd_run_cycles got=%0d exp=100", hi); end
    checks++; if (err !== 1'b1 || STOP !== 1'b1) begin errors++; $display("FAIL wd_err got=e%0b/s%0b exp=e1/s1", err, STOP); end
    checks++; if (bus.conv_en !== 1'b0) begin errors++; $display("FAIL wd_conv_en got=%0b exp=0", bus.conv_en); end
    lat[0] = 3;
    go();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_go_clears got=%0b exp=0", err); end
    wait_done(100, ok);
    checks++; if (!ok || RESULT !== 4'd4) begin errors++; $display("FAIL wd_recover got=%0d exp=4", RESULT); end
  endtask
`else
  task automatic test_watchdog();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_tied got=%0b exp=0", err); end
  endtask
`endif

  initial begin
    rst = 1'b1; GO = 1'b0; desc_we = 1'b0; desc_addr = 4'd0; desc_data = 18'd0;
    GO4 = 1'b0; desc_we4 = 1'b0; desc_addr4 = 2'd0; desc_data4 = 18'd0;
    bus.res_out = 4'd0;
    test_reset();
    test_single_layer();
    test_arm_handshake();
    test_pingpong();
    test_exhaustion();
    test_reset_mid_run();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
